// File: rtl/hbm_delay_drain_if.sv
// Delay-FIFO front entry and NoC output handshake seen by the HBM response drain.
interface hbm_delay_drain_if #(
   parameter int NOC_DATA_WIDTH = 64,
   parameter int TIMERw         = 32
);
   logic                      fifo_empty;
   logic [NOC_DATA_WIDTH-1:0] fifo_flit;
   logic                      fifo_head;
   logic                      fifo_tail;
   logic [TIMERw-1:0]         fifo_exp_time;
   logic                      fifo_rd_en;
   logic                      noc_val_out;
   logic [NOC_DATA_WIDTH-1:0] noc_data_out;
   logic                      noc_rdy_in;

   modport slave (
      input  fifo_empty, fifo_flit, fifo_head, fifo_tail, fifo_exp_time, noc_rdy_in,
      output fifo_rd_en, noc_val_out, noc_data_out
   );

   modport master (
      output fifo_empty, fifo_flit, fifo_head, fifo_tail, fifo_exp_time, noc_rdy_in,
      input  fifo_rd_en, noc_val_out, noc_data_out
   );
endinterface

// File: rtl/hbm_delay_drain.sv
// Releases time-stamped flits from a FWFT delay FIFO once the packet header is due,
// then streams the rest of the packet onto a NoC val/rdy port.
module hbm_delay_drain #(
   parameter int NOC_DATA_WIDTH = 64,
   parameter int TIMERw         = 32,
   parameter int CNTw           = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [TIMERw-1:0]  now_time,
   hbm_delay_drain_if.slave   bus,
   output logic [CNTw-1:0]    pkt_cnt,
   output logic [CNTw-1:0]    late_cnt,
   output logic               proto_err
);
   typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

   state_t            state, state_nxt;
   logic [TIMERw-1:0] diff;
   logic              due, late, load, rel, pop, hdr_pop, err_set;

   // Modular difference keeps the due check correct across time-base wrap.
   assign diff    = now_time - bus.fifo_exp_time;
   assign due     = ~diff[TIMERw-1];
   assign late    = due & (diff != '0);
   assign load    = ~bus.noc_val_out | bus.noc_rdy_in;
   // Heads always wait for their due time; any other flit goes immediately.
   assign rel     = bus.fifo_head ? due : 1'b1;
   assign pop     = rst_n & load & ~bus.fifo_empty & rel;
   assign hdr_pop = pop & bus.fifo_head;
   assign bus.fifo_rd_en = pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      if (!bus.fifo_empty) begin
         case (state)
            IDLE, WAIT, STREAM: begin
               if (bus.fifo_head) begin
                  // A head inside STREAM closes the open packet and starts a new one.
                  if (state == STREAM) err_set = 1'b1;
                  if (pop)           state_nxt = bus.fifo_tail ? IDLE : STREAM;
                  else if (!due)     state_nxt = WAIT;
                  else if (state == STREAM) state_nxt = IDLE;
               end else if (state == STREAM) begin
                  if (pop && bus.fifo_tail) state_nxt = IDLE;
               end else begin
                  err_set = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.noc_val_out  <= 1'b0;
         bus.noc_data_out <= '0;
      end else if (pop) begin
         bus.noc_val_out  <= 1'b1;
         bus.noc_data_out <= bus.fifo_flit;
      end else if (bus.noc_rdy_in) begin
         bus.noc_val_out  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt   <= '0;
         late_cnt  <= '0;
         proto_err <= 1'b0;
      end else begin
         if (hdr_pop && pkt_cnt != '1)          pkt_cnt  <= pkt_cnt + CNTw'(1);
         if (hdr_pop && late && late_cnt != '1) late_cnt <= late_cnt + CNTw'(1);
         if (err_set)                           proto_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_hbm_delay_drain.sv
// Directed bench for hbm_delay_drain: queue-backed FWFT FIFO model, pop/accept logs.
module tb_hbm_delay_drain;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] now_t;
   logic [15:0] pkt_cnt, late_cnt;
   logic        proto_err;

   always #5 clk = ~clk;

   hbm_delay_drain_if #(.NOC_DATA_WIDTH(64), .TIMERw(32)) bus();

   hbm_delay_drain #(.NOC_DATA_WIDTH(64), .TIMERw(32), .CNTw(16)) dut (
      .clk(clk), .rst_n(rst_n), .now_time(now_t), .bus(bus.slave),
      .pkt_cnt(pkt_cnt), .late_cnt(late_cnt), .proto_err(proto_err)
   );

   typedef struct {
      logic [63:0] flit;
      bit          head;
      bit          tail;
      logic [31:0] exp_t;
   } ent_t;

   ent_t        q[$];
   logic [31:0] pop_log[$];
   logic [31:0] acc_now[$];
   logic [63:0] acc_data[$];
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
   endtask

   task automatic drive();
      if (q.size() == 0) begin
         bus.fifo_empty    = 1'b1;
         bus.fifo_flit     = '0;
         bus.fifo_head     = 1'b0;
         bus.fifo_tail     = 1'b0;
         bus.fifo_exp_time = '0;
      end else begin
         bus.fifo_empty    = 1'b0;
         bus.fifo_flit     = q[0].flit;
         bus.fifo_head     = q[0].head;
         bus.fifo_tail     = q[0].tail;
         bus.fifo_exp_time = q[0].exp_t;
      end
   endtask

   task automatic push(input logic [63:0] f, input bit h, input bit t, input logic [31:0] e);
      ent_t x;
      x.flit = f; x.head = h; x.tail = t; x.exp_t = e;
      q.push_back(x);
      drive();
   endtask

   task automatic clear_logs();
      pop_log.delete();
      acc_now.delete();
      acc_data.delete();
   endtask

   // One clock: sample handshakes mid-cycle, then advance FIFO and time base after the edge.
   task automatic cyc();
      bit p;
      @(negedge clk);
      p = bus.fifo_rd_en;
      if (p) pop_log.push_back(now_t);
      if (bus.noc_val_out && bus.noc_rdy_in) begin
         acc_now.push_back(now_t);
         acc_data.push_back(bus.noc_data_out);
      end
      @(posedge clk);
      #1;
      if (p) void'(q.pop_front());
      now_t++;
      drive();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   function automatic logic [63:0] pl(input int i);
      return (i < pop_log.size()) ? {32'h0, pop_log[i]} : 64'hBAD;
   endfunction
   function automatic logic [63:0] an(input int i);
      return (i < acc_now.size()) ? {32'h0, acc_now[i]} : 64'hBAD;
   endfunction
   function automatic logic [63:0] ad(input int i);
      return (i < acc_data.size()) ? acc_data[i] : 64'hBAD;
   endfunction

   initial begin
      rst_n = 1'b0;
      now_t = 32'd100;
      bus.noc_rdy_in = 1'b1;
      drive();
      push(64'hEE, 1'b1, 1'b1, 32'd50);
      #2;
      chk("rst_rd_en", bus.fifo_rd_en, 0);
      chk("rst_val",   bus.noc_val_out, 0);
      chk("rst_data",  bus.noc_data_out, 0);
      chk("rst_pkt",   pkt_cnt, 0);
      chk("rst_late",  late_cnt, 0);
      chk("rst_perr",  proto_err, 0);
      q.delete();
      drive();
      run(2);
      rst_n = 1'b1;

      // 1: 3-flit packet held until now=105
      now_t = 32'd100;
      clear_logs();
      push(64'hA0, 1'b1, 1'b0, 32'd105);
      push(64'hA1, 1'b0, 1'b0, 32'd105);
      push(64'hA2, 1'b0, 1'b1, 32'd105);
      run(12);
      chk("t1_npop", pop_log.size(), 3);
      chk("t1_pop0", pl(0), 105);
      chk("t1_nacc", acc_now.size(), 3);
      chk("t1_v0", an(0), 106);
      chk("t1_v1", an(1), 107);
      chk("t1_v2", an(2), 108);
      chk("t1_d0", ad(0), 64'hA0);
      chk("t1_d2", ad(2), 64'hA2);
      chk("t1_pkt", pkt_cnt, 1);
      chk("t1_late", late_cnt, 0);

      // 2: already-late 2-flit packet
      now_t = 32'd60;
      clear_logs();
      push(64'hB0, 1'b1, 1'b0, 32'd50);
      push(64'hB1, 1'b0, 1'b1, 32'd50);
      run(5);
      chk("t2_pop0", pl(0), 60);
      chk("t2_v0", an(0), 61);
      chk("t2_v1", an(1), 62);
      chk("t2_d1", ad(1), 64'hB1);
      chk("t2_pkt", pkt_cnt, 2);
      chk("t2_late", late_cnt, 1);

      // 3: backpressure mid-packet
      now_t = 32'd200;
      clear_logs();
      push(64'hC0, 1'b1, 1'b0, 32'd200);
      push(64'hC1, 1'b0, 1'b0, 32'd200);
      push(64'hC2, 1'b0, 1'b0, 32'd200);
      push(64'hC3, 1'b0, 1'b1, 32'd200);
      run(2);
      bus.noc_rdy_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         #1;
         chk("t3_stall_val",  bus.noc_val_out, 1);
         chk("t3_stall_data", bus.noc_data_out, 64'hC1);
         chk("t3_stall_rd",   bus.fifo_rd_en, 0);
      end
      bus.noc_rdy_in = 1'b1;
      run(8);
      chk("t3_nacc", acc_data.size(), 4);
      chk("t3_d0", ad(0), 64'hC0);
      chk("t3_d1", ad(1), 64'hC1);
      chk("t3_d2", ad(2), 64'hC2);
      chk("t3_d3", ad(3), 64'hC3);
      chk("t3_npop", pop_log.size(), 4);
      chk("t3_late", late_cnt, 1);

      // 4: expiry across time-base wrap
      now_t = 32'hFFFF_FFFE;
      clear_logs();
      push(64'hD0, 1'b1, 1'b1, 32'h0000_0004);
      run(10);
      chk("t4_npop", pop_log.size(), 1);
      chk("t4_pop0", pl(0), 4);
      chk("t4_v0", an(0), 5);
      chk("t4_pkt", pkt_cnt, 4);
      chk("t4_late", late_cnt, 1);
      chk("t4_perr", proto_err, 0);

      // 5: stray body flit in IDLE, then head-before-tail in STREAM
      now_t = 32'd300;
      clear_logs();
      push(64'hE0, 1'b0, 1'b0, 32'd999);
      push(64'hE1, 1'b1, 1'b0, 32'd300);
      push(64'hE2, 1'b0, 1'b0, 32'd300);
      push(64'hE3, 1'b1, 1'b0, 32'd310);
      push(64'hE4, 1'b0, 1'b1, 32'd310);
      run(15);
      chk("t5_perr", proto_err, 1);
      chk("t5_npop", pop_log.size(), 5);
      chk("t5_pop0", pl(0), 300);
      chk("t5_pop1", pl(1), 301);
      chk("t5_pop2", pl(2), 302);
      chk("t5_pop3", pl(3), 310);
      chk("t5_pop4", pl(4), 311);
      chk("t5_d0", ad(0), 64'hE0);
      chk("t5_d3", ad(3), 64'hE3);
      chk("t5_pkt", pkt_cnt, 6);
      chk("t5_late", late_cnt, 2);

      // 6: asynchronous reset mid-packet, then a fresh packet
      now_t = 32'd400;
      clear_logs();
      push(64'hF0, 1'b1, 1'b0, 32'd400);
      push(64'hF1, 1'b0, 1'b0, 32'd400);
      push(64'hF2, 1'b0, 1'b0, 32'd400);
      push(64'hF3, 1'b0, 1'b1, 32'd400);
      run(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_val",  bus.noc_val_out, 0);
      chk("t6_data", bus.noc_data_out, 0);
      chk("t6_pkt",  pkt_cnt, 0);
      chk("t6_late", late_cnt, 0);
      chk("t6_perr", proto_err, 0);
      chk("t6_rd",   bus.fifo_rd_en, 0);
      q.delete();
      clear_logs();
      push(64'h60, 1'b1, 1'b0, 32'd410);
      push(64'h61, 1'b0, 1'b1, 32'd410);
      run(2);
      rst_n = 1'b1;
      run(14);
      chk("t6_npop", pop_log.size(), 2);
      chk("t6_pop0", pl(0), 410);
      chk("t6_v0", an(0), 411);
      chk("t6_d1", ad(1), 64'h61);
      chk("t6_pkt2", pkt_cnt, 1);
      chk("t6_late2", late_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
